// File: rtl/switch_bank_2_2.sv
// ============================================================================
// Module      : switch_bank_2_2
// Description : Registered bank of NUM_PAIRS 2x2 pass/swap switches with a
//               beat-counter or external control source and a valid pipeline.
//               Optional define SWITCH_BANK_CTRL_OUT_EN adds the outCtrl port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_bank_2_2 #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PAIRS   = 4,
  parameter int PERIOD_LOG2 = 3,
  parameter int PIPE_STAGES = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              mode,
  input  logic [NUM_PAIRS-1:0]              extCtrl,
  input  logic                              inValid,
  input  logic [2*NUM_PAIRS*DATA_WIDTH-1:0] inData,
  output logic                              outValid,
`ifdef SWITCH_BANK_CTRL_OUT_EN
  output logic [NUM_PAIRS-1:0]              outCtrl,
`endif
  output logic [2*NUM_PAIRS*DATA_WIDTH-1:0] outData
);

  localparam int C_BUS_W = 2 * NUM_PAIRS * DATA_WIDTH;

  logic [PERIOD_LOG2:0] r_cnt;
  logic [PERIOD_LOG2:0] w_cnt_use;
  logic [NUM_PAIRS-1:0] w_ctrl;
  logic [C_BUS_W-1:0]   w_sw;

  // A start pulse coinciding with a beat makes that beat see a cleared counter.
  assign w_cnt_use = start ? '0 : r_cnt;
  assign w_ctrl    = mode ? extCtrl : {NUM_PAIRS{w_cnt_use[PERIOD_LOG2]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inValid) begin
      r_cnt <= w_cnt_use + (PERIOD_LOG2 + 1)'(1);
    end else if (start) begin
      r_cnt <= '0;
    end
  end

  generate
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
      assign w_sw[(2*p)*DATA_WIDTH +: DATA_WIDTH] = w_ctrl[p]
          ? inData[(2*p+1)*DATA_WIDTH +: DATA_WIDTH]
          : inData[(2*p)*DATA_WIDTH +: DATA_WIDTH];
      assign w_sw[(2*p+1)*DATA_WIDTH +: DATA_WIDTH] = w_ctrl[p]
          ? inData[(2*p)*DATA_WIDTH +: DATA_WIDTH]
          : inData[(2*p+1)*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [PIPE_STAGES-1:0] r_vld;
  logic [C_BUS_W-1:0]     r_data [PIPE_STAGES];

  // Data stages are enabled by the valid of the stage feeding them, so the
  // output word holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      r_vld[0] <= inValid;
      if (inValid) begin
        r_data[0] <= w_sw;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign outValid = r_vld[PIPE_STAGES-1];
  assign outData  = r_data[PIPE_STAGES-1];

`ifdef SWITCH_BANK_CTRL_OUT_EN
  logic [NUM_PAIRS-1:0] r_ctrl [PIPE_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_ctrl[s] <= '0;
      end
    end else begin
      if (inValid) begin
        r_ctrl[0] <= w_ctrl;
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (r_vld[s-1]) begin
          r_ctrl[s] <= r_ctrl[s-1];
        end
      end
    end
  end

  assign outCtrl = r_ctrl[PIPE_STAGES-1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_bank_2_2.sv
// ============================================================================
// Module      : tb_switch_bank_2_2
// Description : Directed vector bench for switch_bank_2_2 (two configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_bank_2_2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: 2 pairs, PERIOD_LOG2=1, 1 stage
  logic        a_start, a_mode, a_vld, a_ovld;
  logic [1:0]  a_ext;
  logic [31:0] a_din, a_dout;
  // Instance B: 4 pairs, PERIOD_LOG2=0, 2 stages
  logic        b_start, b_mode, b_vld, b_ovld;
  logic [3:0]  b_ext;
  logic [63:0] b_din, b_dout;
`ifdef SWITCH_BANK_CTRL_OUT_EN
  logic [1:0]  a_octrl;
  logic [3:0]  b_octrl;
`endif

  switch_bank_2_2 #(.DATA_WIDTH(8), .NUM_PAIRS(2), .PERIOD_LOG2(1), .PIPE_STAGES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .mode(a_mode), .extCtrl(a_ext),
    .inValid(a_vld), .inData(a_din), .outValid(a_ovld),
`ifdef SWITCH_BANK_CTRL_OUT_EN
    .outCtrl(a_octrl),
`endif
    .outData(a_dout)
  );

  switch_bank_2_2 #(.DATA_WIDTH(8), .NUM_PAIRS(4), .PERIOD_LOG2(0), .PIPE_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .extCtrl(b_ext),
    .inValid(b_vld), .inData(b_din), .outValid(b_ovld),
`ifdef SWITCH_BANK_CTRL_OUT_EN
    .outCtrl(b_octrl),
`endif
    .outData(b_dout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic        md;
    logic [1:0]  ext;
    logic        vld;
    logic [31:0] din;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  ec;
  } vec_t;

  localparam logic [31:0] D   = 32'h04030201;
  localparam logic [31:0] DS  = 32'h03040102;
  localparam logic [31:0] D2  = 32'h44332211;
  localparam logic [31:0] D2S = 32'h33441122;

  localparam logic [63:0] L   = 64'h0706050403020100;
  localparam logic [63:0] LS  = 64'h0607040502030001;
  localparam logic [63:0] LX  = 64'h0706040503020001;

  vec_t tbl [27];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[2]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[5]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[6]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[8]  = '{1'b0, 1'b0, 2'b00, 1'b1, D2,  1'b1, D2,  2'b00};
    tbl[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0, D2, 2'b00};
    tbl[10] = '{1'b0, 1'b0, 2'b00, 1'b1, D2,  1'b1, D2,  2'b00};
    tbl[11] = '{1'b0, 1'b0, 2'b00, 1'b1, D2,  1'b1, D2S, 2'b11};
    tbl[12] = '{1'b1, 1'b0, 2'b00, 1'b0, D,   1'b0, D2S, 2'b11};
    tbl[13] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[14] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[15] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[16] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[17] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[18] = '{1'b1, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[19] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, D,   2'b00};
    tbl[20] = '{1'b0, 1'b0, 2'b00, 1'b1, D,   1'b1, DS,  2'b11};
    tbl[21] = '{1'b0, 1'b1, 2'b10, 1'b1, D2,  1'b1, 32'h33442211, 2'b10};
    tbl[22] = '{1'b0, 1'b1, 2'b01, 1'b1, D2,  1'b1, 32'h44331122, 2'b01};
    tbl[23] = '{1'b0, 1'b1, 2'b00, 1'b1, D2,  1'b1, D2,  2'b00};
    tbl[24] = '{1'b0, 1'b0, 2'b00, 1'b1, D2,  1'b1, D2S, 2'b11};
    tbl[25] = '{1'b0, 1'b1, 2'b00, 1'b1, D2,  1'b1, D2,  2'b00};
    tbl[26] = '{1'b0, 1'b0, 2'b11, 1'b1, D,   1'b1, D,   2'b00};
  end

  logic       pat_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       pat_e [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [63:0] pat_d [6] = '{64'h0, L, L, L, LS, LS};

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_mode = 1'b0; a_ext = '0; a_vld = 1'b0; a_din = '0;
    b_start = 1'b0; b_mode = 1'b0; b_ext = '0; b_vld = 1'b0; b_din = '0;
    repeat (2) tick();
    chk("rst_a_valid", {63'b0, a_ovld}, 64'h0);
    chk("rst_a_data",  {32'b0, a_dout}, 64'h0);
    chk("rst_b_valid", {63'b0, b_ovld}, 64'h0);
    chk("rst_b_data",  b_dout, 64'h0);
`ifdef SWITCH_BANK_CTRL_OUT_EN
    chk("rst_a_ctrl", {62'b0, a_octrl}, 64'h0);
    chk("rst_b_ctrl", {60'b0, b_octrl}, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Counter mode, wrap, bubble hold, start, external mode on instance A
    for (int i = 0; i < 27; i++) begin
      a_start = tbl[i].st; a_mode = tbl[i].md; a_ext = tbl[i].ext;
      a_vld = tbl[i].vld;  a_din = tbl[i].din;
      tick();
      chk($sformatf("vec%0d_valid", i), {63'b0, a_ovld}, {63'b0, tbl[i].ev});
      chk($sformatf("vec%0d_data", i),  {32'b0, a_dout}, {32'b0, tbl[i].ed});
`ifdef SWITCH_BANK_CTRL_OUT_EN
      chk($sformatf("vec%0d_ctrl", i),  {62'b0, a_octrl}, {62'b0, tbl[i].ec});
`endif
    end
    a_vld = 1'b0; a_start = 1'b0; a_mode = 1'b0;

    // Bubbles 1,0,0,1 through the 2-stage instance, PERIOD_LOG2=0
    for (int i = 0; i < 6; i++) begin
      b_vld = pat_v[i];
      b_din = pat_v[i] ? L : 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      chk($sformatf("bub%0d_valid", i), {63'b0, b_ovld}, {63'b0, pat_e[i]});
      chk($sformatf("bub%0d_data", i),  b_dout, pat_d[i]);
    end

    // Reset mid-stream
    b_din = L; b_vld = 1'b1;
    repeat (3) tick();
    b_vld = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'b0, b_ovld}, 64'h0);
    chk("midrst_data",  b_dout, 64'h0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst%0d_valid", i), {63'b0, b_ovld}, 64'h0);
    end
    b_din = 64'h0B0A; b_vld = 1'b1; b_mode = 1'b0;
    tick();
    b_vld = 1'b0;
    chk("postrst_lat_valid", {63'b0, b_ovld}, 64'h0);
    tick();
    chk("postrst_beat_valid", {63'b0, b_ovld}, 64'h1);
    chk("postrst_beat_data",  b_dout, 64'h0B0A);
`ifdef SWITCH_BANK_CTRL_OUT_EN
    chk("postrst_beat_ctrl", {60'b0, b_octrl}, 64'h0);
`endif

    // External mode on the 4-pair instance
    b_mode = 1'b1; b_ext = 4'b0101; b_din = L; b_vld = 1'b1;
    tick();
    b_vld = 1'b0; b_mode = 1'b0; b_ext = '0;
    tick();
    chk("ext_valid", {63'b0, b_ovld}, 64'h1);
    chk("ext_data",  b_dout, LX);
`ifdef SWITCH_BANK_CTRL_OUT_EN
    chk("ext_ctrl", {60'b0, b_octrl}, 64'h5);
`endif
    tick();
    chk("ext_hold_valid", {63'b0, b_ovld}, 64'h0);
    chk("ext_hold_data",  b_dout, LX);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
